mem_copy_engine: RTL and testbench

Block-copy initiator that drives both ports of the team's dual-port synchronous-read RAM: port 1 streams reads from a source range, port 2 writes the returned words to a destination range.
- Throughput: one word per cycle after a one-cycle prime.
- Control handshake: start/busy/done toward the sequencer, used for bulk moves of program/data images without processor involvement.

---
 rtl/mem_copy_engine.sv | 133 +++++++++++++
 tb/tb_mem_copy_engine.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - dual-port RAM block copy engine; optional checksum output via COPY_CHECKSUM_EN
module mem_copy_engine #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr1,
    output logic [DATA_W-1:0] ram_datain1,
    output logic              ram_we1,
    input  logic [DATA_W-1:0] ram_dataout1,
    output logic [ADDR_W-1:0] ram_addr2,
    output logic [DATA_W-1:0] ram_datain2,
`ifdef COPY_CHECKSUM_EN
    output logic              ram_we2,
    output logic [DATA_W-1:0] checksum
`else
    output logic              ram_we2
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] src_q, dst_q, len_q;
    logic [ADDR_W:0]   rd_idx, wr_idx;
    logic              rd_pend;
    logic [ADDR_W-1:0] addr1_q, addr2_q;

    logic              accept;
    logic              rd_go, wr_go, wr_last;
    logic [ADDR_W-1:0] rd_addr, wr_addr;

    assign accept  = (state == S_IDLE) && start;
    assign rd_go   = (state == S_RUN) && (rd_idx < {1'b0, len_q});
    assign wr_go   = (state == S_RUN) && rd_pend;
    assign wr_last = wr_go && (wr_idx == ({1'b0, len_q} - 1'b1));
    assign rd_addr = src_q + rd_idx[ADDR_W-1:0];
    assign wr_addr = dst_q + wr_idx[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (length != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (wr_last) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Addresses show the live access, otherwise the last one issued.
    // Reset suppresses a write that would coincide with the resetting edge.
    always_comb begin
        busy        = (state == S_RUN);
        done        = (state == S_DONE);
        ram_addr1   = rd_go ? rd_addr : addr1_q;
        ram_addr2   = wr_go ? wr_addr : addr2_q;
        ram_we1     = 1'b0;
        ram_datain1 = '0;
        ram_we2     = wr_go && !reset;
        ram_datain2 = ram_dataout1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend <= 1'b0;
            addr1_q <= '0;
            addr2_q <= '0;
            rd_idx  <= '0;
            wr_idx  <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
        end else if (accept) begin
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            len_q   <= length;
            rd_idx  <= '0;
            wr_idx  <= '0;
            rd_pend <= 1'b0;
        end else if (state == S_RUN) begin
            rd_pend <= rd_go;
            if (rd_go) begin
                rd_idx  <= rd_idx + 1'b1;
                addr1_q <= rd_addr;
            end
            if (wr_go) begin
                wr_idx  <= wr_idx + 1'b1;
                addr2_q <= wr_addr;
            end
        end else begin
            rd_pend <= 1'b0;
        end
    end

`ifdef COPY_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            checksum <= '0;
        end else if (wr_go) begin
            checksum <= checksum + ram_dataout1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - directed bench for mem_copy_engine with a write-before-read dual-port RAM model
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] src_addr, dst_addr, length;
    logic        busy, done;
    logic [11:0] ram_addr1, ram_datain1, ram_dataout1;
    logic        ram_we1;
    logic [11:0] ram_addr2, ram_datain2;
    logic        ram_we2;
`ifdef COPY_CHECKSUM_EN
    logic [11:0] checksum;
`endif

    int checks = 0;
    int passed = 0;
    int wr_total = 0;

    logic [11:0] mem [0:4095];
    logic [11:0] addr_log [0:63];

    always #5 clk = ~clk;

    mem_copy_engine #(.ADDR_W(12), .DATA_W(12)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .ram_addr1    (ram_addr1),
        .ram_datain1  (ram_datain1),
        .ram_we1      (ram_we1),
        .ram_dataout1 (ram_dataout1),
        .ram_addr2    (ram_addr2),
        .ram_datain2  (ram_datain2),
`ifdef COPY_CHECKSUM_EN
        .ram_we2      (ram_we2),
        .checksum     (checksum)
`else
        .ram_we2      (ram_we2)
`endif
    );

    always @(posedge clk) begin
        if (ram_we2) begin
            mem[ram_addr2] <= ram_datain2;
            wr_total <= wr_total + 1;
        end
        if (ram_we1) mem[ram_addr1] <= ram_datain1;
        ram_dataout1 <= (ram_we2 && ram_addr2 == ram_addr1) ? ram_datain2 : mem[ram_addr1];
    end

    task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (ok) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_copy(input logic [11:0] s, input logic [11:0] d, input logic [11:0] l,
                           input int ncyc, output int done_cyc, output int busy_cnt,
                           output int wr_cnt, output int first_wr, output int last_wr);
        @(negedge clk);
        src_addr = s; dst_addr = d; length = l; start = 1'b1;
        done_cyc = 0; busy_cnt = 0; wr_cnt = 0; first_wr = 0; last_wr = 0;
        @(posedge clk);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (ram_we2) begin
                wr_cnt++;
                if (first_wr == 0) first_wr = k;
                last_wr = k;
            end
            if (done && done_cyc == 0) done_cyc = k;
            if (k < 64) addr_log[k] = ram_addr1;
        end
    endtask

    int dc, bc, wc, fw, lw, dcount, base;
    logic [11:0] exp_w [0:3];

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 12'h000;
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy === 1'b0, busy, 1'b0);
        chk("rst_done", done === 1'b0, done, 1'b0);
        chk("rst_we1", ram_we1 === 1'b0, ram_we1, 1'b0);
        chk("rst_we2", ram_we2 === 1'b0, ram_we2, 1'b0);
        chk("rst_addr1", ram_addr1 === 12'h000, ram_addr1, 12'h000);
        chk("rst_addr2", ram_addr2 === 12'h000, ram_addr2, 12'h000);
        chk("rst_datain1", ram_datain1 === 12'h000, ram_datain1, 12'h000);
        reset = 1'b0;

        mem[12'h010] = 12'h111; mem[12'h011] = 12'h222;
        mem[12'h012] = 12'h333; mem[12'h013] = 12'h444;
        exp_w[0] = 12'h111; exp_w[1] = 12'h222; exp_w[2] = 12'h333; exp_w[3] = 12'h444;
        do_copy(12'h010, 12'h100, 12'd4, 10, dc, bc, wc, fw, lw);
        chk("basic_done_cycle", dc === 6, dc, 6);
        chk("basic_busy_cycles", bc === 5, bc, 5);
        chk("basic_writes", wc === 4, wc, 4);
        chk("basic_first_write", fw === 2, fw, 2);
        chk("basic_last_write", lw === 5, lw, 5);
        for (int i = 0; i < 4; i++) begin
            chk("basic_dst_word", mem[12'h100 + i] === exp_w[i], mem[12'h100 + i], exp_w[i]);
        end
`ifdef COPY_CHECKSUM_EN
        chk("basic_checksum", checksum === 12'hAAA, checksum, 12'hAAA);
`endif

        do_copy(12'h010, 12'h200, 12'd0, 5, dc, bc, wc, fw, lw);
        chk("zero_done_cycle", dc === 1, dc, 1);
        chk("zero_busy_cycles", bc === 0, bc, 0);
        chk("zero_writes", wc === 0, wc, 0);
`ifdef COPY_CHECKSUM_EN
        chk("zero_checksum", checksum === 12'h000, checksum, 12'h000);
`endif

        mem[12'hFFE] = 12'h5A1; mem[12'hFFF] = 12'h5A2; mem[12'h000] = 12'h5A3;
        do_copy(12'hFFE, 12'h020, 12'd3, 8, dc, bc, wc, fw, lw);
        chk("wrap_done_cycle", dc === 5, dc, 5);
        chk("wrap_rd_addr0", addr_log[1] === 12'hFFE, addr_log[1], 12'hFFE);
        chk("wrap_rd_addr1", addr_log[2] === 12'hFFF, addr_log[2], 12'hFFF);
        chk("wrap_rd_addr2", addr_log[3] === 12'h000, addr_log[3], 12'h000);
        chk("wrap_dst0", mem[12'h020] === 12'h5A1, mem[12'h020], 12'h5A1);
        chk("wrap_dst1", mem[12'h021] === 12'h5A2, mem[12'h021], 12'h5A2);
        chk("wrap_dst2", mem[12'h022] === 12'h5A3, mem[12'h022], 12'h5A3);

        mem[12'h050] = 12'hABC; mem[12'h051] = 12'h001;
        mem[12'h052] = 12'h002; mem[12'h053] = 12'h003;
        do_copy(12'h050, 12'h051, 12'd3, 8, dc, bc, wc, fw, lw);
        chk("ovl_dst0", mem[12'h051] === 12'hABC, mem[12'h051], 12'hABC);
        chk("ovl_dst1", mem[12'h052] === 12'hABC, mem[12'h052], 12'hABC);
        chk("ovl_dst2", mem[12'h053] === 12'hABC, mem[12'h053], 12'hABC);

        for (int i = 0; i < 8; i++) mem[12'h200 + i] = 12'h700 + 12'(i);
        @(negedge clk);
        src_addr = 12'h200; dst_addr = 12'h300; length = 12'd8; start = 1'b1;
        base = wr_total;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", busy === 1'b0, busy, 1'b0);
        chk("rst_mid_we2", ram_we2 === 1'b0, ram_we2, 1'b0);
        chk("rst_mid_done", done === 1'b0, done, 1'b0);
        reset = 1'b0;
        dcount = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("rst_mid_no_done", dcount === 0, dcount, 0);
        chk("rst_mid_writes", (wr_total - base) === 1, wr_total - base, 1);
        chk("rst_mid_dst0", mem[12'h300] === 12'h700, mem[12'h300], 12'h700);
        chk("rst_mid_dst1", mem[12'h301] === 12'h000, mem[12'h301], 12'h000);
        do_copy(12'h200, 12'h300, 12'd8, 14, dc, bc, wc, fw, lw);
        chk("after_rst_done_cycle", dc === 10, dc, 10);
        chk("after_rst_dst7", mem[12'h307] === 12'h707, mem[12'h307], 12'h707);

        @(negedge clk);
        src_addr = 12'h010; dst_addr = 12'h400; length = 12'd2; start = 1'b1;
        base = wr_total; dc = 0; dcount = 0;
        @(posedge clk);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 5) begin
                chk("held_idle_busy", busy === 1'b0, busy, 1'b0);
            end
            if (k == 6) begin
                start = 1'b0;
                chk("held_second_busy", busy === 1'b1, busy, 1'b1);
            end
            if (done) begin
                dcount++;
                if (dcount == 1) begin
                    chk("held_first_done", k === 4, k, 4);
                end else if (dcount == 2) begin
                    chk("held_second_done", k === 9, k, 9);
                end
            end
        end
        chk("held_done_count", dcount === 2, dcount, 2);
        chk("held_writes", (wr_total - base) === 4, wr_total - base, 4);
        chk("held_dst0", mem[12'h400] === 12'h111, mem[12'h400], 12'h111);
        chk("held_dst1", mem[12'h401] === 12'h222, mem[12'h401], 12'h222);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
